ruleid_packer: RTL
==================

# ruleid_packer

Upstream stage of the rule-ID capture buffer. Packs a stream of 16-bit rule IDs from the matching pipeline into 512-bit words (32 lanes) and presents them as a valid/ready stream whose `out_data`/`out_valid` drive the capture buffer's `in_data`/`in_valid`. A word is emitted when all 32 lanes are filled, when a packet-end marker arrives, or when a partially filled word has been idle for `TIMEOUT` cycles. Rule ID 0 is reserved as lane padding.

## Interface
- `ID_W`, 16: rule ID width.
- `OUT_W`, 512: output word width; lanes `N = OUT_W/ID_W` = 32.
- `TIMEOUT`, 1024: idle cycles before a partial word is flushed; legal range 2..65535.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous, active-high.
- `in_rule_id` in `ID_W`: rule ID.
- `in_last` in 1: last ID of the current packet; forces a flush.
- `in_valid` in 1: input qualifier.
- `in_ready` out 1: input accepted when `in_valid & in_ready`.
- `out_data` out `OUT_W`: packed word; lane k occupies bits [16k+15:16k], lane 0 filled first.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accept. The capture buffer ties it high; the block still honours it.
- `stat_words` out 32: count of words emitted (handshakes on output).
- `stat_ids` out 32: count of nonzero IDs stored into lanes.

## Operation
- Internal assembly buffer (`OUT_W` bits, unused lanes 0), 5-bit `slot` (next free lane), idle counter, and one output register (`out_data`/`out_valid`).
- States:
  - EMPTY: `slot==0`.
  - FILLING: `slot>0`.
  - PENDING: assembly word complete but output register occupied and not draining.
- `in_ready = (state != PENDING)`, combinational from state only.
- Accept with `in_rule_id != 0`: write ID into lane `slot`; increment `slot`; `stat_ids++`.
- Accept with `in_rule_id == 0`: nothing stored; `in_last` still honoured.
- Completion event:
  - accept storing into lane 31; or
  - accept with `in_last=1` and ≥1 lane occupied after that accept; or
  - FILLING, no accept this cycle, and idle counter == `TIMEOUT-1`.
- `in_last` with zero occupied lanes: no word, no state change.
- Output register free when `!out_valid | out_ready`.
- On completion with output register free: word loads into output register at the same edge; assembly clears to EMPTY.
- On completion with output register busy: go to PENDING; the completed word is held.
- PENDING → EMPTY on the first edge where the output register is free; the word moves to output.
- Output handshake (`out_valid & out_ready`) clears `out_valid` unless a new word loads at the same edge; `stat_words++` per handshake.
- Idle counter:
  - clears on every accept and on leaving FILLING;
  - increments each FILLING cycle without accept;
  - frozen in PENDING.
- Counters wrap at 2^32.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `in_ready=1`, `stat_words=0`, `stat_ids=0`. State is EMPTY, `slot=0`, idle counter 0.
- Latency, full or `in_last` completion: `out_valid` is high in the cycle after the accepting edge (1 cycle).
- Latency, timeout: with the last accept at edge t and no further input, `out_valid` rises after edge t+`TIMEOUT`.
- Sustained throughput with `out_ready=1`: one ID per cycle, no bubbles, including back-to-back words.
- `out_ready` low: `out_data` and `out_valid` stay stable until handshake. The block accepts up to 32 more IDs, then enters PENDING and deasserts `in_ready`.
- Simultaneous completion and output handshake at one edge: new word replaces the old; `out_valid` stays 1; `stat_words` increments once.
- `rst` mid-operation: partial and pending words are discarded immediately; outputs go to reset values asynchronously.

## Test plan
- Stream IDs 1..32 back-to-back, `out_ready=1`: one word with lane k = k+1; `out_valid` one cycle after the 32nd accept; `stat_ids=32`, `stat_words=1`.
- Send IDs 0x0005, 0x0007 (last=1): word = 0x0007_0005 in bits [31:0], remaining bits 0; an immediate following ID 0x0009 starts a new word.
- Single ID 0x00AB, then idle with `TIMEOUT=16`: `out_valid` rises 16 cycles after the accept edge; lane 0 = 0x00AB.
- Hold `out_ready=0`, stream 70 IDs: first word held stable; `in_ready` drops after 64 accepts. Raise `out_ready`: words 1 and 2 drain in order and `in_ready` returns to 1.
- IDs 0, 0 with `in_last` on the second: no word emitted, `stat_ids=0`. Then 0x0003, 0x0000, 0x0004 (last): lanes 0..1 = 3, 4.
- Assert `rst` after 10 IDs with `out_valid=1`: `out_valid=0`, counters 0, `in_ready=1` immediately. Next word after release starts at lane 0.

Source files
------------

// File: rtl/ruleid_packer_if.sv
// Rule-ID packer bus: input ID stream, packed output word stream and statistics.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
// the source keeps data stable while valid is high and ready is low.
interface ruleid_packer_if #(
    parameter int ID_W  = 16,
    parameter int OUT_W = 512
);
    logic [ID_W-1:0]  in_rule_id;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      stat_words;
    logic [31:0]      stat_ids;

    // Packer side of the bus
    modport master (
        input  in_rule_id, in_last, in_valid, out_ready,
        output in_ready, out_data, out_valid, stat_words, stat_ids
    );

    // Environment side: ID source and word sink
    modport slave (
        output in_rule_id, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_valid, stat_words, stat_ids
    );
endinterface

// File: rtl/ruleid_packer.sv
// Packs 16-bit rule IDs into 32-lane words. A word is emitted when full, on an
// in_last marker, or after TIMEOUT idle cycles with a partial word. ID 0 is padding
// and never stored. One output register plus one held (PENDING) assembly word.
module ruleid_packer #(
    parameter int ID_W    = 16,
    parameter int OUT_W   = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    ruleid_packer_if.master bus,
    output logic [1:0]  dbg_state_o
);
    localparam int N      = OUT_W / ID_W;
    localparam int SLOT_W = $clog2(N);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N - 1);
    localparam logic [15:0]       IDLE_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FILLING = 2'd1,
        S_PENDING = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [OUT_W-1:0]   asm_q, asm_d;
    logic [15:0]        idle_q, idle_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        stat_words_q, stat_words_d;
    logic [31:0]        stat_ids_q, stat_ids_d;

    logic               accept, store, out_free, complete, occupied;
    logic [OUT_W-1:0]   asm_next;

    // State and datapath registers; reset discards partial and held words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            slot_q       <= '0;
            asm_q        <= '0;
            idle_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            stat_words_q <= '0;
            stat_ids_q   <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            asm_q        <= asm_d;
            idle_q       <= idle_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            stat_words_q <= stat_words_d;
            stat_ids_q   <= stat_ids_d;
        end
    end

    // Next-state: lane write, completion detection, output load and idle timer
    always_comb begin
        accept       = bus.in_valid & (state_q != S_PENDING);
        store        = accept & (bus.in_rule_id != '0);
        out_free     = ~out_valid_q | bus.out_ready;
        occupied     = (slot_q != '0) | store;

        asm_next = asm_q;
        if (store) begin
            asm_next[int'(slot_q) * ID_W +: ID_W] = bus.in_rule_id;
        end

        complete = (store & (slot_q == SLOT_LAST))
                 | (accept & bus.in_last & occupied)
                 | ((state_q == S_FILLING) & ~accept & (idle_q == IDLE_LAST));

        state_d      = state_q;
        slot_d       = slot_q;
        asm_d        = asm_q;
        idle_d       = '0;
        out_data_d   = out_data_q;
        // A handshake empties the output register unless a word loads below
        out_valid_d  = out_valid_q & ~bus.out_ready;
        stat_words_d = stat_words_q + {31'd0, out_valid_q & bus.out_ready};
        stat_ids_d   = stat_ids_q + {31'd0, store};

        case (state_q)
            S_EMPTY, S_FILLING: begin
                if (complete) begin
                    slot_d = '0;
                    if (out_free) begin
                        out_data_d  = asm_next;
                        out_valid_d = 1'b1;
                        asm_d       = '0;
                        state_d     = S_EMPTY;
                    end else begin
                        // Hold the finished word until the output register frees up
                        asm_d   = asm_next;
                        state_d = S_PENDING;
                    end
                end else begin
                    asm_d   = asm_next;
                    slot_d  = slot_q + {{(SLOT_W-1){1'b0}}, store};
                    state_d = occupied ? S_FILLING : S_EMPTY;
                    if ((state_q == S_FILLING) && !accept) begin
                        idle_d = idle_q + 16'd1;
                    end
                end
            end
            S_PENDING: begin
                idle_d = idle_q;
                if (out_free) begin
                    out_data_d  = asm_q;
                    out_valid_d = 1'b1;
                    asm_d       = '0;
                    state_d     = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
                slot_d  = '0;
                asm_d   = '0;
            end
        endcase
    end

    assign bus.in_ready   = (state_q != S_PENDING);
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.stat_words = stat_words_q;
    assign bus.stat_ids   = stat_ids_q;
    assign dbg_state_o    = state_q;
endmodule
